// File: rtl/mips_cpu_run_pkg.sv
// rtl/mips_cpu_run_pkg.sv - shared types for the MIPS CPU run monitor
package mips_cpu_run_pkg;

    localparam int STATUS_W = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_WAIT_ACTIVE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } run_state_t;

    typedef enum logic [STATUS_W-1:0] {
        ST_NONE         = 3'd0,
        ST_HALT         = 3'd1,
        ST_TIMEOUT      = 3'd2,
        ST_BUS_HANG     = 3'd3,
        ST_NO_ACTIVE    = 3'd4,
        ST_BUS_CONFLICT = 3'd5
    } run_status_t;

endpackage

// File: rtl/mips_cpu_sat_counter.sv
// rtl/mips_cpu_sat_counter.sv - clearable up-counter that sticks at all-ones
module mips_cpu_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && count != '1) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/mips_cpu_run_monitor.sv
// rtl/mips_cpu_run_monitor.sv - CPU run sequencer, halt/timeout detector and bus monitor
module mips_cpu_run_monitor
    import mips_cpu_run_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100,
    parameter int RESET_CYCLES   = 1,
    parameter int STALL_LIMIT    = 16,
    parameter int CNT_W          = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    output logic                cpu_reset,
    input  logic                cpu_active,
    input  logic [31:0]         cpu_register_v0,
    input  logic                bus_read,
    input  logic                bus_write,
    input  logic                bus_waitrequest,
    output logic                done,
    output logic [STATUS_W-1:0] status,
    output logic [31:0]         result,
    output logic [CNT_W-1:0]    cycle_count,
    output logic [CNT_W-1:0]    read_count,
    output logic [CNT_W-1:0]    write_count,
    output logic [CNT_W-1:0]    stall_count
);

    localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int SC_W = $clog2(STALL_LIMIT + 1);
    // A timeout wider than the cycle counter can never be reached.
    localparam bit TO_REACHABLE = (CNT_W >= 31) || (TIMEOUT_CYCLES < (1 << CNT_W));

    run_state_t          state, state_n;
    run_status_t         status_q, status_n;
    logic [31:0]         result_q, result_n;
    logic [RC_W-1:0]     rst_cnt, rst_cnt_n;
    logic [SC_W-1:0]     consec, consec_n;
    logic [CNT_W-1:0]    cyc_next;
    logic                clr, in_run, stall;
    logic                cyc_inc, rd_inc, wr_inc, st_inc;

    assign in_run   = (state == S_RUN);
    assign stall    = (bus_read || bus_write) && bus_waitrequest;
    assign cyc_next = (cycle_count == '1) ? cycle_count : cycle_count + CNT_W'(1);

    assign cyc_inc  = (state == S_WAIT_ACTIVE) || in_run;
    assign rd_inc   = in_run && bus_read && !bus_waitrequest;
    assign wr_inc   = in_run && bus_write && !bus_waitrequest;
    assign st_inc   = in_run && stall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            status_q <= ST_NONE;
            result_q <= '0;
            rst_cnt  <= '0;
            consec   <= '0;
        end else begin
            state    <= state_n;
            status_q <= status_n;
            result_q <= result_n;
            rst_cnt  <= rst_cnt_n;
            consec   <= consec_n;
        end
    end

    always_comb begin
        state_n   = state;
        status_n  = status_q;
        result_n  = result_q;
        rst_cnt_n = rst_cnt;
        consec_n  = '0;
        clr       = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n   = S_RESET;
                    status_n  = ST_NONE;
                    result_n  = '0;
                    rst_cnt_n = '0;
                    clr       = 1'b1;
                end
            end
            S_RESET: begin
                if (rst_cnt == RC_W'(RESET_CYCLES - 1)) begin
                    state_n = S_WAIT_ACTIVE;
                end else begin
                    rst_cnt_n = rst_cnt + RC_W'(1);
                end
            end
            S_WAIT_ACTIVE: begin
                if (cpu_active) begin
                    state_n = S_RUN;
                end else begin
                    state_n  = S_DONE;
                    status_n = ST_NO_ACTIVE;
                end
            end
            S_RUN: begin
                consec_n = stall ? consec + SC_W'(1) : '0;
                // Exit conditions are checked in priority order; halt wins.
                if (!cpu_active) begin
                    state_n = S_DRAIN;
                end else if (bus_read && bus_write) begin
                    state_n  = S_DONE;
                    status_n = ST_BUS_CONFLICT;
                end else if (consec_n == SC_W'(STALL_LIMIT)) begin
                    state_n  = S_DONE;
                    status_n = ST_BUS_HANG;
                end else if (TO_REACHABLE && cyc_next == CNT_W'(TIMEOUT_CYCLES)) begin
                    state_n  = S_DONE;
                    status_n = ST_TIMEOUT;
                end
            end
            S_DRAIN: begin
                // Sample $v0 one cycle after halt so the last writeback is visible.
                state_n  = S_DONE;
                status_n = ST_HALT;
                result_n = cpu_register_v0;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign cpu_reset = (state == S_IDLE) || (state == S_RESET) || (state == S_DONE);
    assign done      = (state == S_DONE);
    assign status    = status_q;
    assign result    = result_q;

    mips_cpu_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk(clk), .rst_n(reset_n), .clr(clr), .inc(cyc_inc), .count(cycle_count)
    );
    mips_cpu_sat_counter #(.W(CNT_W)) u_read_cnt (
        .clk(clk), .rst_n(reset_n), .clr(clr), .inc(rd_inc), .count(read_count)
    );
    mips_cpu_sat_counter #(.W(CNT_W)) u_write_cnt (
        .clk(clk), .rst_n(reset_n), .clr(clr), .inc(wr_inc), .count(write_count)
    );
    mips_cpu_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk(clk), .rst_n(reset_n), .clr(clr), .inc(st_inc), .count(stall_count)
    );

endmodule

// File: tb/tb_mips_cpu_run_monitor.sv
// tb/tb_mips_cpu_run_monitor.sv - self-checking bench for mips_cpu_run_monitor
module tb_mips_cpu_run_monitor;

    localparam int TO  = 100;
    localparam int RC  = 3;
    localparam int SL  = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start = 1'b0;
    logic        cpu_reset;
    logic        cpu_active = 1'b0;
    logic [31:0] cpu_register_v0 = '0;
    logic        bus_read = 1'b0, bus_write = 1'b0, bus_waitrequest = 1'b0;
    logic        done;
    logic [2:0]  status;
    logic [31:0] result, cycle_count, read_count, write_count, stall_count;

    int total = 0;
    int bad   = 0;

    mips_cpu_run_monitor #(
        .TIMEOUT_CYCLES(TO), .RESET_CYCLES(RC), .STALL_LIMIT(SL), .CNT_W(32)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .cpu_reset(cpu_reset),
        .cpu_active(cpu_active), .cpu_register_v0(cpu_register_v0),
        .bus_read(bus_read), .bus_write(bus_write), .bus_waitrequest(bus_waitrequest),
        .done(done), .status(status), .result(result), .cycle_count(cycle_count),
        .read_count(read_count), .write_count(write_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 cpu held in reset, 2 awaiting active,
    // 3 running, 4 settling after halt, 5 finished.
    int          m_phase, m_hold, m_cyc, m_rd, m_wr, m_st, m_run_stall, m_status;
    logic [31:0] m_result;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase <= 0; m_hold <= 0; m_cyc <= 0; m_rd <= 0; m_wr <= 0; m_st <= 0;
            m_run_stall <= 0; m_status <= 0; m_result <= '0;
        end else if ((m_phase == 0 || m_phase == 5) && start) begin
            m_phase <= 1; m_hold <= RC; m_cyc <= 0; m_rd <= 0; m_wr <= 0; m_st <= 0;
            m_run_stall <= 0; m_status <= 0; m_result <= '0;
        end else if (m_phase == 1) begin
            m_hold <= m_hold - 1;
            if (m_hold == 1) m_phase <= 2;
        end else if (m_phase == 2) begin
            m_cyc <= m_cyc + 1;
            if (cpu_active) m_phase <= 3;
            else begin m_phase <= 5; m_status <= 4; end
        end else if (m_phase == 3) begin
            m_cyc <= m_cyc + 1;
            m_rd  <= m_rd + int'(bus_read && !bus_waitrequest);
            m_wr  <= m_wr + int'(bus_write && !bus_waitrequest);
            m_st  <= m_st + int'((bus_read || bus_write) && bus_waitrequest);
            m_run_stall <= ((bus_read || bus_write) && bus_waitrequest) ? m_run_stall + 1 : 0;
            if (!cpu_active) m_phase <= 4;
            else if (bus_read && bus_write) begin m_phase <= 5; m_status <= 5; end
            else if ((bus_read || bus_write) && bus_waitrequest && m_run_stall + 1 == SL)
                begin m_phase <= 5; m_status <= 3; end
            else if (m_cyc + 1 == TO) begin m_phase <= 5; m_status <= 2; end
        end else if (m_phase == 4) begin
            m_phase <= 5; m_status <= 1; m_result <= cpu_register_v0;
        end
    end

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            chk("m_cpu_reset", 32'(cpu_reset), 32'(m_phase == 0 || m_phase == 1 || m_phase == 5));
            chk("m_done", 32'(done), 32'(m_phase == 5));
            chk("m_cycle_count", cycle_count, 32'(m_cyc));
            chk("m_read_count", read_count, 32'(m_rd));
            chk("m_write_count", write_count, 32'(m_wr));
            chk("m_stall_count", stall_count, 32'(m_st));
            if (m_phase == 5) begin
                chk("m_status", 32'(status), 32'(m_status));
                chk("m_result", result, m_result);
            end
        end
    end

    // Pulses start and checks the cpu_reset window; returns on the first
    // falling edge where the CPU is out of reset.
    task automatic launch();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("start_clears_done", 32'(done), 32'd0);
        chk("start_clears_cycles", cycle_count, 32'd0);
        chk("start_clears_stalls", stall_count, 32'd0);
        for (int i = 1; i < RC; i++) begin
            @(negedge clk);
            chk("cpu_reset_window", 32'(cpu_reset), 32'd1);
        end
        @(negedge clk);
        chk("cpu_reset_released", 32'(cpu_reset), 32'd0);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done !== 1'b1; i++) @(negedge clk);
        chk("wait_done", 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        #3;
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_status", 32'(status), 32'd0);
        chk("rst_counters", cycle_count | read_count | write_count | stall_count, 32'd0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;

        // Halt: active for 20 cycles after release, v0 = 0x2A.
        cpu_active = 1'b1; cpu_register_v0 = 32'h0000_002A;
        launch();
        repeat (20) @(negedge clk);
        cpu_active = 1'b0;
        wait_done(10);
        chk("halt_status", 32'(status), 32'd1);
        chk("halt_result", result, 32'h2A);
        chk("halt_cycles", cycle_count, 32'd21);
        chk("halt_cpu_reset", 32'(cpu_reset), 32'd1);
        repeat (3) @(negedge clk);
        chk("done_holds", 32'(done), 32'd1);

        // Timeout: CPU never halts.
        cpu_active = 1'b1; cpu_register_v0 = 32'h1234_5678;
        launch();
        wait_done(200);
        chk("to_status", 32'(status), 32'd2);
        chk("to_cycles", cycle_count, 32'd100);
        chk("to_result", result, 32'd0);

        // Bus hang: read stuck in waitrequest.
        launch();
        bus_read = 1'b1; bus_waitrequest = 1'b1;
        wait_done(60);
        bus_read = 1'b0; bus_waitrequest = 1'b0;
        chk("hang_status", 32'(status), 32'd3);
        chk("hang_stalls", stall_count, 32'd16);
        chk("hang_reads", read_count, 32'd0);
        chk("hang_cycles", cycle_count, 32'd17);

        // Conflict: read and write in the same RUN cycle.
        launch();
        @(negedge clk); bus_read = 1'b1; bus_write = 1'b1;
        @(negedge clk); bus_read = 1'b0; bus_write = 1'b0;
        chk("conflict_done", 32'(done), 32'd1);
        chk("conflict_status", 32'(status), 32'd5);

        // No active.
        cpu_active = 1'b0;
        launch();
        wait_done(10);
        chk("noact_status", 32'(status), 32'd4);
        chk("noact_cycles", cycle_count, 32'd1);

        // Traffic: 3 reads with 2 wait cycles each, then 2 writes, then halt.
        cpu_active = 1'b1; cpu_register_v0 = 32'hCAFE_0001;
        launch();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bus_read = 1'b1; bus_waitrequest = 1'b1;
            @(negedge clk); @(negedge clk);
            bus_waitrequest = 1'b0;
            @(negedge clk);
            bus_read = 1'b0;
        end
        bus_write = 1'b1;
        @(negedge clk); @(negedge clk);
        bus_write = 1'b0;
        @(negedge clk);
        cpu_active = 1'b0;
        wait_done(10);
        chk("traffic_reads", read_count, 32'd3);
        chk("traffic_writes", write_count, 32'd2);
        chk("traffic_stalls", stall_count, 32'd6);
        chk("traffic_status", 32'(status), 32'd1);
        chk("traffic_result", result, 32'hCAFE_0001);

        // Asynchronous reset mid-run.
        cpu_active = 1'b1;
        launch();
        bus_read = 1'b1;
        repeat (5) @(negedge clk);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("async_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("async_done", 32'(done), 32'd0);
        chk("async_status", 32'(status), 32'd0);
        chk("async_cycles", cycle_count, 32'd0);
        chk("async_reads", read_count, 32'd0);
        bus_read = 1'b0;
        @(posedge clk); #3;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_reset", 32'(done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
